// File: rtl/rounding_shift_mac_pkg.sv
// Shared constants for the shift-based approximate MAC datapath.
package rounding_shift_mac_pkg;

    localparam int unsigned DEF_WIDTH      = 16;
    localparam int unsigned DEF_LOG2_WIDTH = 4;
    localparam int unsigned DEF_ACC_WIDTH  = 40;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

    // b shifted by up to WIDTH positions always fits losslessly in 2*WIDTH+1 bits.
    function automatic int unsigned prod_width(input int unsigned width);
        return 2 * width + 1;
    endfunction

    localparam int unsigned DEF_PROD_WIDTH = 2 * DEF_WIDTH + 1;

endpackage

// File: rtl/rs_onehot_index.sv
// Highest-set-bit locator for a power-of-two rounded operand, with zero and
// multi-hot flags so callers can detect a malformed one-hot input.
module rs_onehot_index #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned LOG2_WIDTH = 4
) (
    input  logic [WIDTH:0]      value,
    output logic [LOG2_WIDTH:0] index,
    output logic                zero,
    output logic                multi_hot
);

    localparam int unsigned IDX_W = LOG2_WIDTH + 1;

    // Priority scan upward so the last hit is the most significant set bit.
    always_comb begin
        index = '0;
        for (int unsigned i = 0; i <= WIDTH; i++) begin
            if (value[i]) begin
                index = IDX_W'(i);
            end
        end
        zero      = (value == '0);
        multi_hot = ((value & (value - 1'b1)) != '0);
    end

endmodule

// File: rtl/rounding_shift_mac.sv
// Approximate MAC: multiplies b by a power-of-two operand via shift, accumulates
// over a vector terminated by in_last, and emits sum and element count.
module rounding_shift_mac
    import rounding_shift_mac_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LOG2_WIDTH = DEF_LOG2_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH:0]       ar,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] result,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err_onehot
);

    localparam int unsigned PROD_WIDTH = prod_width(WIDTH);
    localparam int unsigned IDX_W      = LOG2_WIDTH + 1;

    logic                  adv;
    logic                  fire;
    logic                  load;
    logic [IDX_W-1:0]      idx;
    logic                  ar_zero;
    logic                  ar_multi;
    logic [PROD_WIDTH-1:0] prod_next;

    logic                  s1_valid;
    logic                  s1_last;
    logic [PROD_WIDTH-1:0] s1_prod;
    logic [ACC_WIDTH-1:0]  acc;
    logic [CNT_WIDTH-1:0]  elem_cnt;
    logic [ACC_WIDTH-1:0]  sum;
    logic [CNT_WIDTH-1:0]  cnt_n;

    rs_onehot_index #(
        .WIDTH      (WIDTH),
        .LOG2_WIDTH (LOG2_WIDTH)
    ) u_index (
        .value     (ar),
        .index     (idx),
        .zero      (ar_zero),
        .multi_hot (ar_multi)
    );

    // The whole pipeline moves together whenever the output slot is free or draining.
    always_comb begin
        adv       = !out_valid || out_ready;
        in_ready  = adv;
        fire      = in_valid && adv;
        load      = adv && s1_valid && s1_last;
        prod_next = ar_zero ? '0 : (PROD_WIDTH'(b) << idx);
        sum       = acc + ACC_WIDTH'(s1_prod);
        cnt_n     = elem_cnt + CNT_WIDTH'(1);
    end

    // Stage 1: capture the shifted product and flag non-one-hot operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_prod    <= '0;
            err_onehot <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (fire) begin
                s1_prod <= prod_next;
                s1_last <= in_last;
                if (ar_multi) begin
                    err_onehot <= 1'b1;
                end
            end
        end
    end

    // Stage 2: accumulate, and on the last element move the total into the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            elem_cnt  <= '0;
            result    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (adv && s1_valid) begin
                if (s1_last) begin
                    result    <= sum;
                    count     <= cnt_n;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    elem_cnt  <= '0;
                end else begin
                    acc      <= sum;
                    elem_cnt <= cnt_n;
                end
            end
            // A simultaneous reload keeps out_valid high with the new result.
            if (!load && out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rounding_shift_mac.sv
// Self-checking bench for rounding_shift_mac: directed scenarios plus a
// randomized run scored against a behavioural vector-sum model.
module tb_rounding_shift_mac;

    typedef struct {
        logic [39:0] res;
        logic [15:0] cnt;
    } rec_t;

    logic        clk;
    logic        rst_n;
    logic [16:0] ar;
    logic [15:0] b;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [39:0] result;
    logic [15:0] count;
    logic        out_valid;
    logic        out_ready;
    logic        err_onehot;

    logic        in_ready8;
    logic [7:0]  result8;
    logic [15:0] count8;
    logic        out_valid8;
    logic        err8;

    int checks;
    int errors;

    // Reference model state
    longint unsigned m_sum;
    int unsigned     m_cnt;
    bit              exp_err;
    rec_t            exp_q[$];
    rec_t            obs_q[$];
    logic [7:0]      exp8_q[$];
    logic [7:0]      obs8_q[$];

    rounding_shift_mac dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ar         (ar),
        .b          (b),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .result     (result),
        .count      (count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_onehot (err_onehot)
    );

    rounding_shift_mac #(
        .ACC_WIDTH (8)
    ) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ar         (ar),
        .b          (b),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready8),
        .result     (result8),
        .count      (count8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready),
        .err_onehot (err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every result handed over to the consumer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) obs_q.push_back('{result, count});
        if (rst_n && out_valid8 && out_ready) obs8_q.push_back(result8);
    end

    // ar*b where ar is taken as 2^(highest set bit), or 0 when ar is 0.
    function automatic longint unsigned ref_prod(input logic [16:0] a, input logic [15:0] bb);
        int hi = -1;
        for (int i = 0; i <= 16; i++) if (a[i]) hi = i;
        if (hi < 0) return 0;
        return longint'(bb) * (64'd1 << hi);
    endfunction

    task automatic model_clear();
        m_sum = 0;
        m_cnt = 0;
        exp_err = 0;
        exp_q.delete();
        exp8_q.delete();
        obs_q.delete();
        obs8_q.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    // Offer one element until accepted; updates the reference model on acceptance.
    task automatic send(input logic [16:0] a, input logic [15:0] bb, input logic l,
                        input bit rnd_ready);
        logic rdy;
        bit   done = 0;
        ar = a;
        b = bb;
        in_last = l;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1;
                m_sum += ref_prod(a, bb);
                m_cnt++;
                if ($countones(a) > 1) exp_err = 1;
                if (l) begin
                    exp_q.push_back('{m_sum[39:0], m_cnt[15:0]});
                    exp8_q.push_back(m_sum[7:0]);
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: in_ready never 1 within 200 cycles, required accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (result !== 40'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
        checks++;
        if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++;
        if (err_onehot !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_onehot); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(17'h00008, 16'd5, 1'b0, 0);
        send(17'h00010, 16'd3, 1'b0, 0);
        send(17'h00001, 16'd7, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b want 1", out_valid); end
        checks++;
        if (result !== 40'd95) begin errors++; $display("FAIL basic_result: got %0d want 95", result); end
        checks++;
        if (count !== 16'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", count); end
        checks++;
        if (err_onehot !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err_onehot); end
        drain();
    endtask

    task automatic test_zero_operand();
        out_ready = 1'b1;
        send(17'h00000, 16'hFFFF, 1'b0, 0);
        send(17'h10000, 16'd1, 1'b1, 0);
        @(posedge clk);
        #1;
        checks++;
        if (result !== 40'd65536 || count !== 16'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_operand: got result=%0d count=%0d valid=%b want 65536 2 1",
                     result, count, out_valid);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(17'h00002, 16'd4, 1'b1, 0);
        send(17'h00004, 16'd4, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || result !== 40'd8 || count !== 16'd1) begin
            errors++;
            $display("FAIL b2b_first: got valid=%b result=%0d count=%0d want 1 8 1",
                     out_valid, result, count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 40'd16 || count !== 16'd1) begin
            errors++;
            $display("FAIL b2b_second: got valid=%b result=%0d count=%0d want 1 16 1",
                     out_valid, result, count);
        end
        drain();
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        send(17'h10000, 16'd1, 1'b1, 0);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid8 !== 1'b1 || result8 !== 8'd0 || count8 !== 16'd1) begin
            errors++;
            $display("FAIL wrap_acc8: got valid=%b result=%0d count=%0d want 1 0 1",
                     out_valid8, result8, count8);
        end
        checks++;
        if (result !== 40'd65536) begin errors++; $display("FAIL wrap_acc40: got %0d want 65536", result); end
        drain();
    endtask

    task automatic test_backpressure();
        bit seen = 0;
        obs_q.delete();
        out_ready = 1'b0;
        send(17'h00001, 16'd10, 1'b0, 0);
        send(17'h00002, 16'd10, 1'b1, 0);
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_timeout: out_valid never rose, want 1"); end
        ar = 17'h00004;
        b = 16'd1;
        in_last = 1'b1;
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 40'd30 || count !== 16'd2) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b result=%0d count=%0d want 1 30 2",
                         out_valid, result, count);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send(17'h00004, 16'd1, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b want 0", out_valid); end
        drain();
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL bp_count: got %0d results want 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].res !== 40'd30 || obs_q[1].res !== 40'd4 || obs_q[1].cnt !== 16'd1) begin
                errors++;
                $display("FAIL bp_results: got %0d,%0d/%0d want 30,4/1",
                         obs_q[0].res, obs_q[1].res, obs_q[1].cnt);
            end
        end
    endtask

    task automatic test_reset_mid_vector();
        out_ready = 1'b1;
        send(17'h00001, 16'd5, 1'b0, 0);
        send(17'h00001, 16'd6, 1'b0, 0);
        do_reset();
        send(17'h00001, 16'd9, 1'b1, 0);
        drain();
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL rst_mid_count: got %0d results want 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].res !== 40'd9 || obs_q[0].cnt !== 16'd1) begin
                errors++;
                $display("FAIL rst_mid_result: got %0d/%0d want 9/1", obs_q[0].res, obs_q[0].cnt);
            end
        end
    endtask

    task automatic test_non_onehot();
        out_ready = 1'b1;
        send(17'h00003, 16'd2, 1'b1, 0);
        @(posedge clk);
        #1;
        checks++;
        if (result !== 40'd4 || err_onehot !== 1'b1) begin
            errors++;
            $display("FAIL nonhot: got result=%0d err=%b want 4 1", result, err_onehot);
        end
        drain();
        send(17'h00001, 16'd1, 1'b1, 0);
        drain();
        checks++;
        if (err_onehot !== 1'b1) begin errors++; $display("FAIL nonhot_sticky: got %b want 1", err_onehot); end
    endtask

    task automatic test_random();
        logic [16:0] a;
        int          len;
        int          sel;
        do_reset();
        for (int v = 0; v < 30; v++) begin
            len = $urandom_range(1, 5);
            for (int e = 0; e < len; e++) begin
                sel = $urandom_range(0, 19);
                if (sel == 0) a = '0;
                else if (sel == 1) a = 17'($urandom);
                else a = 17'd1 << $urandom_range(0, 16);
                send(a, 16'($urandom), 1'(e == len - 1), 1);
            end
        end
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d results want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].res !== exp_q[i].res || obs_q[i].cnt !== exp_q[i].cnt) begin
                errors++;
                $display("FAIL rand_vec%0d: got %0d/%0d want %0d/%0d", i,
                         obs_q[i].res, obs_q[i].cnt, exp_q[i].res, exp_q[i].cnt);
            end
        end
        checks++;
        if (obs8_q.size() != exp8_q.size()) begin
            errors++;
            $display("FAIL rand8_count: got %0d want %0d", obs8_q.size(), exp8_q.size());
        end
        for (int i = 0; i < obs8_q.size() && i < exp8_q.size(); i++) begin
            checks++;
            if (obs8_q[i] !== exp8_q[i]) begin
                errors++;
                $display("FAIL rand8_vec%0d: got %0d want %0d", i, obs8_q[i], exp8_q[i]);
            end
        end
        checks++;
        if (err_onehot !== exp_err || err8 !== exp_err) begin
            errors++;
            $display("FAIL rand_err: got %b/%b want %b", err_onehot, err8, exp_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ar = '0;
        b = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_zero_operand();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_reset_mid_vector();
        test_non_onehot();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
